// File: rtl/bist_ctrl.sv
// rtl/bist_ctrl.sv - BIST sequencer driving an exhaustive count into a CUT and checking the MISR signature
//
// Purpose: on start, seed the MISR for one cycle, drive patterns 0..N_PAT-1
// into the CUT while the MISR compacts, then compare the signature against
// GOLDEN and report sticky done/pass.
//
// Parameters: PAT_W (pattern width), SIG_W (signature width),
//             N_PAT (patterns applied, 1..2^PAT_W), GOLDEN (expected signature).
// Ports:
//   clk       - clock, all state changes on rising edge
//   rst       - synchronous active-high reset
//   start     - run request, only looked at while idle
//   abort     - cancel a run in progress
//   pat       - pattern to the CUT (counter value while running, else 0)
//   misr_seed - MISR seed/reset control, high = load seed on next edge
//   sig       - current MISR output
//   busy      - high whenever a run is in progress
//   done      - sticky, set when a run completes
//   pass      - sticky, signature matched GOLDEN (meaningful while done)
//   sig_cap   - captured signature, only with BIST_SIG_CAPTURE_EN defined
//
// Optional feature macro: BIST_SIG_CAPTURE_EN adds the sig_cap register/port.
module bist_ctrl #(
   parameter int               PAT_W  = 4,
   parameter int               SIG_W  = 5,
   parameter int               N_PAT  = 16,
   parameter logic [SIG_W-1:0] GOLDEN = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [PAT_W-1:0] pat,
   output logic             misr_seed,
   input  logic [SIG_W-1:0] sig,
   output logic             busy,
   output logic             done,
   output logic             pass
`ifdef BIST_SIG_CAPTURE_EN
   ,
   output logic [SIG_W-1:0] sig_cap
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SEED  = 2'd1,
      S_RUN   = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   // Final pattern index; the counter stops here instead of wrapping, so
   // N_PAT = 2^PAT_W simply ends on the all-ones value.
   localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(N_PAT - 1);

   state_t           state;
   state_t           state_nx;
   logic [PAT_W-1:0] cnt;
   logic [PAT_W-1:0] cnt_nx;
   logic             done_nx;
   logic             pass_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         done  <= 1'b0;
         pass  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         done  <= done_nx;
         pass  <= pass_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      done_nx  = done;
      pass_nx  = pass;
      case (state)
         S_IDLE: begin
            // abort is deliberately not looked at here, so start wins.
            if (start) begin
               state_nx = S_SEED;
               cnt_nx   = '0;
               done_nx  = 1'b0;
               pass_nx  = 1'b0;
            end
         end
         S_SEED: begin
            if (abort) begin
               state_nx = S_IDLE;
               done_nx  = 1'b0;
               pass_nx  = 1'b0;
            end else begin
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_nx = S_IDLE;
               done_nx  = 1'b0;
               pass_nx  = 1'b0;
            end else if (cnt == LAST_PAT) begin
               state_nx = S_CHECK;
            end else begin
               cnt_nx = cnt + PAT_W'(1);
            end
         end
         S_CHECK: begin
            // sig already holds the signature after N_PAT compaction steps.
            if (abort) begin
               state_nx = S_IDLE;
               done_nx  = 1'b0;
               pass_nx  = 1'b0;
            end else begin
               state_nx = S_IDLE;
               done_nx  = 1'b1;
               pass_nx  = (sig == GOLDEN);
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Outputs decode only registered state/counter, never inputs.
   assign pat       = (state == S_RUN) ? cnt : '0;
   assign misr_seed = (state != S_RUN);
   assign busy      = (state != S_IDLE);

`ifdef BIST_SIG_CAPTURE_EN
   // Kept across later starts so a failing signature stays visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_cap <= '0;
      end else if ((state == S_CHECK) && !abort) begin
         sig_cap <= sig;
      end
   end
`endif

endmodule

// File: tb/tb_bist_ctrl.sv
// tb/tb_bist_ctrl.sv - scoreboard bench for bist_ctrl with behavioural CUT/MISR and reference model
`timescale 1ns/1ps
module tb_bist_ctrl;

   localparam int               PAT_W = 4;
   localparam int               SIG_W = 5;
   localparam int               NI    = 3;
   localparam logic [SIG_W-1:0] SEED  = 5'b10101;

   function automatic logic [SIG_W-1:0] cut_fn(input logic [PAT_W-1:0] p);
      return {^p, p ^ {p[1:0], p[3:2]}};
   endfunction

   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                  input logic [SIG_W-1:0] r);
      return {m[3:0], m[4] ^ m[1]} ^ r;
   endfunction

   // Signature after applying patterns 0..n-1 to a freshly seeded MISR.
   function automatic logic [SIG_W-1:0] sig_after(input int n);
      logic [SIG_W-1:0] m;
      int               k;
      m = SEED;
      for (k = 0; k < n; k++) m = misr_step(m, cut_fn(k[PAT_W-1:0]));
      return m;
   endfunction

   function automatic int np(input int i);
      return (i == 2) ? 1 : 16;
   endfunction

   function automatic logic [SIG_W-1:0] gold(input int i);
      if (i == 0) return sig_after(16);
      if (i == 1) return sig_after(16) ^ 5'b00001;
      return sig_after(1);
   endfunction

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [PAT_W-1:0] pat_o  [NI];
   logic             seed_o [NI];
   logic             busy_o [NI];
   logic             done_o [NI];
   logic             pass_o [NI];
`ifdef BIST_SIG_CAPTURE_EN
   logic [SIG_W-1:0] cap_o  [NI];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [SIG_W-1:0] misr;
      bist_ctrl #(
         .PAT_W (PAT_W),
         .SIG_W (SIG_W),
         .N_PAT (np(g)),
         .GOLDEN(gold(g))
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .start    (start),
         .abort    (abort),
         .pat      (pat_o[g]),
         .misr_seed(seed_o[g]),
         .sig      (misr),
         .busy     (busy_o[g]),
         .done     (done_o[g]),
         .pass     (pass_o[g])
`ifdef BIST_SIG_CAPTURE_EN
         ,
         .sig_cap  (cap_o[g])
`endif
      );
      always @(posedge clk) misr <= seed_o[g] ? SEED : misr_step(misr, cut_fn(pat_o[g]));
   end

   typedef struct {
      int               done_cyc;
      logic             pass;
      logic [SIG_W-1:0] sig;
   } exp_t;

   exp_t             sb [NI][$];
   int               run_e0   [NI];
   logic             exp_done [NI];
   logic             exp_pass [NI];
   logic [SIG_W-1:0] exp_cap  [NI];
   logic             done_q   [NI];
   int               cyc    = 0;
   int               checks = 0;
   int               errors = 0;
   logic             chk_en = 1'b0;

   initial begin
      for (int i = 0; i < NI; i++) begin
         run_e0[i]   = -1;
         exp_done[i] = 1'b0;
         exp_pass[i] = 1'b0;
         exp_cap[i]  = '0;
         done_q[i]   = 1'b0;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: a run is just "accepted at edge e0, finished at e0+N+2".
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            if (run_e0[i] >= 0 && sb[i].size() > 0) void'(sb[i].pop_back());
            run_e0[i]   = -1;
            exp_done[i] = 1'b0;
            exp_pass[i] = 1'b0;
            exp_cap[i]  = '0;
         end else if (run_e0[i] >= 0) begin
            if (abort) begin
               if (sb[i].size() > 0) void'(sb[i].pop_back());
               run_e0[i]   = -1;
               exp_done[i] = 1'b0;
               exp_pass[i] = 1'b0;
            end else if (cyc == run_e0[i] + np(i) + 2) begin
               run_e0[i]   = -1;
               exp_done[i] = 1'b1;
               exp_pass[i] = (sig_after(np(i)) == gold(i));
               exp_cap[i]  = sig_after(np(i));
            end
         end else if (start) begin
            run_e0[i]   = cyc;
            exp_done[i] = 1'b0;
            exp_pass[i] = 1'b0;
            sb[i].push_back('{cyc + np(i) + 3, (sig_after(np(i)) == gold(i)), sig_after(np(i))});
         end
      end
   end

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cyc=%0d got=%0h expected=%0h", name, i, cyc, act, exp);
      end
   endtask

   int               d;
   logic             eb;
   logic             es;
   logic [PAT_W-1:0] ep;
   exp_t             e;

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            eb = (run_e0[i] >= 0);
            d  = cyc - 1 - run_e0[i];
            ep = '0;
            es = 1'b1;
            if (eb && d >= 1 && d <= np(i)) begin
               ep = PAT_W'(d - 1);
               es = 1'b0;
            end
            chk("busy", i, 32'(busy_o[i]), 32'(eb));
            chk("pat", i, 32'(pat_o[i]), 32'(ep));
            chk("misr_seed", i, 32'(seed_o[i]), 32'(es));
            chk("done_level", i, 32'(done_o[i]), 32'(exp_done[i]));
            if (exp_done[i]) chk("pass_level", i, 32'(pass_o[i]), 32'(exp_pass[i]));
`ifdef BIST_SIG_CAPTURE_EN
            chk("sig_cap_level", i, 32'(cap_o[i]), 32'(exp_cap[i]));
`endif
            if (done_o[i] === 1'b1 && done_q[i] !== 1'b1) begin
               if (sb[i].size() == 0) begin
                  chk("unexpected_done", i, 32'd1, 32'd0);
               end else begin
                  e = sb[i].pop_front();
                  chk("done_time", i, 32'(cyc), 32'(e.done_cyc));
                  chk("pass", i, 32'(pass_o[i]), 32'(e.pass));
`ifdef BIST_SIG_CAPTURE_EN
                  chk("sig_cap", i, 32'(cap_o[i]), 32'(e.sig));
`endif
               end
            end
            done_q[i] = done_o[i];
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_pat(input logic [PAT_W-1:0] v);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (pat_o[0] === v) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_pat timeout waiting for pat=%0d got=%0d", v, pat_o[0]);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(5);

      // good/bad run, plus N_PAT=1 instance alongside
      pulse_start();
      idle(22);

      // start while busy at pattern 7
      pulse_start();
      wait_pat(4'd7);
      pulse_start();
      idle(20);

      // abort at pattern 5
      pulse_start();
      wait_pat(4'd5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      idle(3);

      // start and abort together while idle, then reset mid-run at pattern 10
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      wait_pat(4'd10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(3);

      // fresh run after reset
      pulse_start();
      idle(22);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 39) == 0);
         rst   = ($urandom_range(0, 149) == 0);
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      idle(25);

      for (int i = 0; i < NI; i++) chk("queue_empty", i, 32'(sb[i].size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
